// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Register map, bit positions and FSM states for the MMIO UART TX.
//  Revision : 1.0  initial release
// ============================================================================
package uart_pkg;

  // Word offsets within the 16-byte window (bus_addr[3:2])
  localparam logic [1:0] c_OFS_TXDATA = 2'd0;
  localparam logic [1:0] c_OFS_STATUS = 2'd1;
  localparam logic [1:0] c_OFS_BAUD   = 2'd2;
  localparam logic [1:0] c_OFS_CTRL   = 2'd3;

  localparam int c_STAT_BUSY      = 0;
  localparam int c_STAT_FULL      = 1;
  localparam int c_STAT_EMPTY     = 2;
  localparam int c_STAT_OVF       = 3;
  localparam int c_STAT_LEVEL_LSB = 8;

  localparam int c_CTRL_TX_EN    = 0;
  localparam int c_CTRL_PAR_EN   = 1;
  localparam int c_CTRL_PAR_ODD  = 2;
  localparam int c_CTRL_TWO_STOP = 3;
  localparam int c_CTRL_IRQ_EN   = 4;
  localparam int c_CTRL_FLUSH    = 5;

  localparam int         c_CTRL_W     = 5;
  localparam logic [4:0] c_CTRL_RESET = 5'h01;

  localparam int c_MIN_DIV = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo
//  Purpose  : Single-clock FIFO with push/pop/flush and full/empty/level flags.
//  Revision : 1.0  initial release
// ============================================================================
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int c_AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_AW:0]    r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_level == '0);
  assign o_full    = (r_level == (c_AW+1)'(DEPTH));
  assign o_level   = r_level;
  assign o_data    = r_mem[r_rd_ptr];
  // A push into a full FIFO is still legal when a pop frees a slot this cycle
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + c_AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + c_AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + (c_AW+1)'(1);
        2'b01:   r_level <= r_level - (c_AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_mmio.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_mmio
//  Purpose  : Memory-mapped buffered UART transmitter with FIFO, divisor, IRQ.
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int DATA_BITS   = 8,
  parameter int DEFAULT_DIV = 868,
  parameter int DIV_W       = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  bus_addr,
  input  logic        bus_we,
  input  logic        bus_re,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        tx,
  output logic        irq
);
  localparam int               c_LVL_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int               c_BCNT_W  = $clog2(DATA_BITS + 1);
  localparam logic [DIV_W-1:0] c_DIV_MIN = DIV_W'(c_MIN_DIV);
  localparam logic [DIV_W-1:0] c_DIV_RST = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] c_DIV_ONE = DIV_W'(1);

  // Register file
  logic [DIV_W-1:0]    r_div;
  logic [c_CTRL_W-1:0] r_ctrl;
  logic                r_flush;
  logic                r_ovf;

  // Per-frame shifter state
  tx_state_e           r_state;
  tx_state_e           w_state_nxt;
  logic [DATA_BITS-1:0] r_shift;
  logic [c_BCNT_W-1:0] r_bitcnt;
  logic [DIV_W-1:0]    r_baud;
  logic [DIV_W-1:0]    r_div_f;
  logic                r_par_en_f;
  logic                r_two_stop_f;
  logic                r_par_bit;
  logic                r_stop2;
  logic                r_tx;
  logic                r_irq;
  logic                r_active;

  logic                w_wr_txdata;
  logic                w_wr_status;
  logic                w_wr_baud;
  logic                w_wr_ctrl;
  logic [DIV_W-1:0]    w_wdiv;
  logic                w_pop;
  logic                w_push;
  logic                w_drop;
  logic                w_tick;
  logic                w_last_bit;
  logic                w_tx_nxt;
  logic                w_busy;
  logic                w_fifo_full;
  logic                w_fifo_empty;
  logic [c_LVL_W-1:0]  w_level;
  logic [DATA_BITS-1:0] w_fifo_rdata;
  logic                w_unused_bits;

  assign w_wr_txdata = bus_we && (bus_addr[3:2] == c_OFS_TXDATA);
  assign w_wr_status = bus_we && (bus_addr[3:2] == c_OFS_STATUS);
  assign w_wr_baud   = bus_we && (bus_addr[3:2] == c_OFS_BAUD);
  assign w_wr_ctrl   = bus_we && (bus_addr[3:2] == c_OFS_CTRL);
  assign w_wdiv      = bus_wdata[DIV_W-1:0];
  assign w_push      = w_wr_txdata && (!w_fifo_full || w_pop);
  assign w_drop      = w_wr_txdata && w_fifo_full && !w_pop;
  assign w_busy      = (r_state != ST_IDLE) || r_active || !w_fifo_empty;
  assign w_unused_bits = ^{bus_re, bus_addr[1:0], bus_wdata};

  assign tx  = r_tx;
  assign irq = r_irq;

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (r_flush),
    .i_data  (bus_wdata[DATA_BITS-1:0]),
    .o_data  (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_level (w_level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div   <= c_DIV_RST;
      r_ctrl  <= c_CTRL_RESET;
      r_flush <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_flush <= w_wr_ctrl && bus_wdata[c_CTRL_FLUSH];
      if (w_wr_baud) begin
        r_div <= (w_wdiv < c_DIV_MIN) ? c_DIV_MIN : w_wdiv;
      end
      if (w_wr_ctrl) begin
        r_ctrl <= bus_wdata[c_CTRL_W-1:0];
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (w_wr_status && bus_wdata[c_STAT_OVF]) begin
        r_ovf <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // tx is the registered image of the current state, so it trails r_state by one clock
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_tx_nxt    = 1'b1;
    w_tick      = (r_baud == '0);
    w_last_bit  = (r_bitcnt == c_BCNT_W'(DATA_BITS - 1));
    case (r_state)
      ST_IDLE: begin
        if (r_ctrl[c_CTRL_TX_EN] && !w_fifo_empty && !r_flush) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        w_tx_nxt = 1'b0;
        if (w_tick) w_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        w_tx_nxt = r_shift[0];
        if (w_tick && w_last_bit) w_state_nxt = r_par_en_f ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        w_tx_nxt = r_par_bit;
        if (w_tick) w_state_nxt = ST_STOP;
      end
      ST_STOP: begin
        if (w_tick && (!r_two_stop_f || r_stop2)) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift      <= '0;
      r_bitcnt     <= '0;
      r_baud       <= '0;
      r_div_f      <= c_DIV_RST;
      r_par_en_f   <= 1'b0;
      r_two_stop_f <= 1'b0;
      r_par_bit    <= 1'b0;
      r_stop2      <= 1'b0;
      r_tx         <= 1'b1;
      r_irq        <= 1'b0;
      r_active     <= 1'b0;
    end else begin
      r_tx     <= w_tx_nxt;
      r_active <= (r_state != ST_IDLE);
      r_irq    <= r_ctrl[c_CTRL_IRQ_EN] && w_fifo_empty && (r_state == ST_IDLE);
      if (w_pop) begin
        // Frame format is frozen here; later register writes apply to the next frame
        r_shift      <= w_fifo_rdata;
        r_div_f      <= r_div;
        r_baud       <= r_div - c_DIV_ONE;
        r_bitcnt     <= '0;
        r_stop2      <= 1'b0;
        r_par_en_f   <= r_ctrl[c_CTRL_PAR_EN];
        r_two_stop_f <= r_ctrl[c_CTRL_TWO_STOP];
        r_par_bit    <= (^w_fifo_rdata) ^ r_ctrl[c_CTRL_PAR_ODD];
      end else if (r_state != ST_IDLE) begin
        if (w_tick) begin
          r_baud <= r_div_f - c_DIV_ONE;
          if (r_state == ST_DATA) begin
            r_shift  <= r_shift >> 1;
            r_bitcnt <= r_bitcnt + c_BCNT_W'(1);
          end
          if (r_state == ST_STOP) begin
            r_stop2 <= 1'b1;
          end
        end else begin
          r_baud <= r_baud - c_DIV_ONE;
        end
      end
    end
  end

  always_comb begin
    bus_rdata = '0;
    case (bus_addr[3:2])
      c_OFS_STATUS: begin
        bus_rdata[c_STAT_BUSY]  = w_busy;
        bus_rdata[c_STAT_FULL]  = w_fifo_full;
        bus_rdata[c_STAT_EMPTY] = w_fifo_empty;
        bus_rdata[c_STAT_OVF]   = r_ovf;
        bus_rdata[c_STAT_LEVEL_LSB +: 8] = 8'(w_level);
      end
      c_OFS_BAUD: bus_rdata[DIV_W-1:0]    = r_div;
      c_OFS_CTRL: bus_rdata[c_CTRL_W-1:0] = r_ctrl;
      default:    bus_rdata = '0;
    endcase
  end

endmodule
`default_nettype wire
